// File: rtl/ras_checkpoint_queue_pkg.sv
// Shared types for the RAS checkpoint queue: sizes, queue pointers
// (index + phase bit) and the RAS checkpoint payload.
package ras_checkpoint_queue_pkg;

    localparam int RAS_INDEX_WIDTH      = 4;
    localparam int RAS_CKPT_ENTRY_NUM   = 16;
    localparam int RAS_CKPT_INDEX_WIDTH = $clog2(RAS_CKPT_ENTRY_NUM);

    typedef logic [RAS_INDEX_WIDTH-1:0]      RAS_IndexPath;
    typedef logic [RAS_CKPT_INDEX_WIDTH-1:0] RAS_CkptQueueIndexPath;
    typedef logic [RAS_CKPT_INDEX_WIDTH:0]   RAS_CkptQueueCountPath;

    // MSB is the wrap/phase bit.
    typedef struct packed {
        logic                  phase;
        RAS_CkptQueueIndexPath index;
    } RAS_CkptQueuePtrPath;

    typedef struct packed {
        RAS_IndexPath stackTopPtr;
        RAS_IndexPath queueTailPtr;
    } RAS_CheckpointData;

    function automatic RAS_CkptQueuePtrPath ptrAdd(
        RAS_CkptQueuePtrPath   ptr,
        RAS_CkptQueueCountPath n
    );
        return RAS_CkptQueuePtrPath'(RAS_CkptQueueCountPath'(ptr) + n);
    endfunction

endpackage

// File: rtl/ras_checkpoint_queue_if.sv
// Fetch / resolve / commit side bundle of the RAS checkpoint queue.
// master: fetch + resolution + commit logic; slave: the queue.
interface ras_checkpoint_queue_if;
    import ras_checkpoint_queue_pkg::*;

    logic                  alloc_valid;
    RAS_CheckpointData     alloc_ckpt;
    logic                  alloc_ready;
    RAS_CkptQueueIndexPath alloc_tag;
    logic                  commit_valid;
    logic                  mispredict_valid;
    RAS_CkptQueueIndexPath mispredict_tag;
    logic                  flush_all;
    logic                  recover_valid;
    RAS_CheckpointData     recover_ckpt;
    RAS_CkptQueueCountPath count;
    logic                  error;

    modport master (
        output alloc_valid, alloc_ckpt, commit_valid,
        output mispredict_valid, mispredict_tag, flush_all,
        input  alloc_ready, alloc_tag, recover_valid,
        input  recover_ckpt, count, error
    );

    modport slave (
        input  alloc_valid, alloc_ckpt, commit_valid,
        input  mispredict_valid, mispredict_tag, flush_all,
        output alloc_ready, alloc_tag, recover_valid,
        output recover_ckpt, count, error
    );

endinterface

// File: rtl/ras_ckpt_ram.sv
// Checkpoint storage: one write port, one asynchronous read port.
// Ports: clk, wrEn/wrAddr/wrData (write), rdAddr/rdData (read).
module ras_ckpt_ram
    import ras_checkpoint_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  wrEn,
    input  RAS_CkptQueueIndexPath wrAddr,
    input  RAS_CheckpointData     wrData,
    input  RAS_CkptQueueIndexPath rdAddr,
    output RAS_CheckpointData     rdData
);

    RAS_CheckpointData mem [RAS_CKPT_ENTRY_NUM];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/ras_checkpoint_queue.sv
// Program-order RAS checkpoint queue: alloc at tail, commit at head,
// recover by tag. Ports: clk, rst (sync, high), ckptBus (slave).
module ras_checkpoint_queue
    import ras_checkpoint_queue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    ras_checkpoint_queue_if.slave  ckptBus
);

    RAS_CkptQueuePtrPath   headPtr;
    RAS_CkptQueuePtrPath   tailPtr;
    RAS_CkptQueuePtrPath   mispPtr;
    RAS_CkptQueueIndexPath tagOffset;
    RAS_CkptQueueCountPath liveCount;
    RAS_CheckpointData     readData;
    logic                  empty;
    logic                  full;
    logic                  allocReady;
    logic                  allocFire;
    logic                  commitFire;
    logic                  tagLive;
    logic                  recoverValid;
    RAS_CheckpointData     recoverCkpt;
    logic                  errorFlag;

    localparam RAS_CkptQueueCountPath ONE = RAS_CkptQueueCountPath'(1);

    assign liveCount  = RAS_CkptQueueCountPath'(tailPtr)
                      - RAS_CkptQueueCountPath'(headPtr);
    assign empty      = (headPtr == tailPtr);
    assign full       = (headPtr.index == tailPtr.index)
                     && (headPtr.phase != tailPtr.phase);
    assign allocReady = !full && !ckptBus.mispredict_valid
                     && !ckptBus.flush_all;
    assign allocFire  = ckptBus.alloc_valid && allocReady;
    assign commitFire = ckptBus.commit_valid && !empty;

    // Distance from head decides liveness; head + distance also
    // yields the tag's full pointer with the correct phase bit.
    assign tagOffset = ckptBus.mispredict_tag - headPtr.index;
    assign tagLive   = {1'b0, tagOffset} < liveCount;
    assign mispPtr   = ptrAdd(headPtr, {1'b0, tagOffset});

    ras_ckpt_ram ram (
        .clk    (clk),
        .wrEn   (allocFire),
        .wrAddr (tailPtr.index),
        .wrData (ckptBus.alloc_ckpt),
        .rdAddr (ckptBus.mispredict_tag),
        .rdData (readData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr      <= '0;
            tailPtr      <= '0;
            recoverValid <= 1'b0;
            recoverCkpt  <= '0;
            errorFlag    <= 1'b0;
        end else begin
            recoverValid <= 1'b0;
            if (commitFire) headPtr <= ptrAdd(headPtr, ONE);
            if (ckptBus.flush_all) begin
                // Land on the post-commit head so the queue is empty.
                tailPtr <= commitFire ? ptrAdd(headPtr, ONE) : headPtr;
            end else if (ckptBus.mispredict_valid) begin
                if (tagLive) begin
                    tailPtr      <= ptrAdd(mispPtr, ONE);
                    recoverValid <= 1'b1;
                    recoverCkpt  <= readData;
                end else begin
                    errorFlag <= 1'b1;
                end
            end else if (allocFire) begin
                tailPtr <= ptrAdd(tailPtr, ONE);
            end
            if (ckptBus.commit_valid && empty) errorFlag <= 1'b1;
        end
    end

    assign ckptBus.alloc_ready   = allocReady;
    assign ckptBus.alloc_tag     = tailPtr.index;
    assign ckptBus.recover_valid = recoverValid;
    assign ckptBus.recover_ckpt  = recoverCkpt;
    assign ckptBus.count         = liveCount;
    assign ckptBus.error         = errorFlag;

endmodule

// File: tb/tb_ras_checkpoint_queue.sv
// Vector/scoreboard bench for ras_checkpoint_queue.
// Vectors carry stimulus plus pre-edge and post-edge expectations.
module tb_ras_checkpoint_queue;
    import ras_checkpoint_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ras_checkpoint_queue_if bus();

    ras_checkpoint_queue dut (
        .clk     (clk),
        .rst     (rst),
        .ckptBus (bus.slave)
    );

    typedef struct {
        logic       av;
        logic [7:0] ck;
        logic       cv;
        logic       mv;
        logic [3:0] tag;
        logic       fl;
        logic       rs;
        logic       eRdy;
        logic [3:0] eTag;
        logic [4:0] eCnt;
        logic       eRv;
        logic [7:0] eRck;
        logic       eErr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(
        logic av, logic [7:0] ck, logic cv, logic mv, logic [3:0] tag,
        logic fl, logic rs, logic eRdy, logic [3:0] eTag,
        logic [4:0] eCnt, logic eRv, logic [7:0] eRck, logic eErr
    );
        vec_t v;
        v.av = av; v.ck = ck; v.cv = cv; v.mv = mv; v.tag = tag;
        v.fl = fl; v.rs = rs; v.eRdy = eRdy; v.eTag = eTag;
        v.eCnt = eCnt; v.eRv = eRv; v.eRck = eRck; v.eErr = eErr;
        vecs.push_back(v);
    endtask

    task automatic idleInputs();
        bus.alloc_valid      = 1'b0;
        bus.alloc_ckpt       = '0;
        bus.commit_valid     = 1'b0;
        bus.mispredict_valid = 1'b0;
        bus.mispredict_tag   = '0;
        bus.flush_all        = 1'b0;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        idleInputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_rv", 32'(bus.recover_valid), 32'd0);
        chk("rst_rck", 32'(bus.recover_ckpt), 32'd0);
        chk("rst_err", 32'(bus.error), 32'd0);
        chk("rst_tag", 32'(bus.alloc_tag), 32'd0);
        chk("rst_rdy", 32'(bus.alloc_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then a rejected 17th alloc.
        for (int i = 0; i < 16; i++)
            add(1, {4'(i), 4'(i + 1)}, 0, 0, 0, 0, 0,
                1, 4'(i), 5'(i + 1), 0, 0, 0);
        add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0);
        // Commit 4, second lap of 4 allocs, mispredict tag 1.
        for (int k = 0; k < 4; k++)
            add(0, 0, 1, 0, 0, 0, 0, k != 0, 0, 5'(15 - k), 0, 0, 0);
        for (int k = 0; k < 4; k++)
            add(1, {4'(k + 8), 4'(k + 9)}, 0, 0, 0, 0, 0,
                1, 4'(k), 5'(13 + k), 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 4, 14, 1, 8'h9A, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 2, 14, 0, 0, 0);
        // Flush with a concurrent (rejected) alloc, then reset.
        add(1, 8'h55, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
        // Alloc 5, mispredict tag 2, alloc gets tag 3.
        for (int i = 0; i < 5; i++)
            add(1, {4'(i), 4'(i + 1)}, 0, 0, 0, 0, 0,
                1, 4'(i), 5'(i + 1), 0, 0, 0);
        add(0, 0, 0, 1, 2, 0, 0, 0, 5, 3, 1, 8'h23, 0);
        add(1, 8'h77, 0, 0, 0, 0, 0, 1, 3, 4, 0, 0, 0);
        // Commit to 3 live, then alloc+commit+mispredict(head+1).
        add(0, 0, 1, 0, 0, 0, 0, 1, 4, 3, 0, 0, 0);
        add(1, 8'h88, 1, 1, 2, 0, 0, 0, 4, 1, 1, 8'h23, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
        // Non-live tag, drain, commit while empty.
        add(0, 0, 0, 1, 7, 0, 0, 0, 3, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
        // Back-to-back mispredicts.
        for (int i = 0; i < 3; i++)
            add(1, 8'(8'hC0 + i), 0, 0, 0, 0, 0,
                1, 4'(3 + i), 5'(1 + i), 0, 0, 1);
        add(0, 0, 0, 1, 5, 0, 0, 0, 6, 3, 1, 8'hC2, 1);
        add(0, 0, 0, 1, 3, 0, 0, 0, 6, 1, 1, 8'hC0, 1);
        // Seven live entries, flush.
        for (int i = 0; i < 6; i++)
            add(1, 8'(8'hE0 + i), 0, 0, 0, 0, 0,
                1, 4'(4 + i), 5'(2 + i), 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 10, 0, 0, 0, 1);
        // Reset during a recover pulse cycle.
        for (int i = 0; i < 2; i++)
            add(1, 8'(8'hD0 + i), 0, 0, 0, 0, 0,
                1, 4'(3 + i), 5'(1 + i), 0, 0, 1);
        add(0, 0, 0, 1, 3, 0, 0, 0, 5, 1, 1, 8'hD0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        foreach (vecs[n]) begin
            @(negedge clk);
            bus.alloc_valid      = vecs[n].av;
            bus.alloc_ckpt       = vecs[n].ck;
            bus.commit_valid     = vecs[n].cv;
            bus.mispredict_valid = vecs[n].mv;
            bus.mispredict_tag   = vecs[n].tag;
            bus.flush_all        = vecs[n].fl;
            rst                  = vecs[n].rs;
            sb.push_back(vecs[n]);
            #1;
            chk($sformatf("v%0d_rdy", n),
                32'(bus.alloc_ready), 32'(vecs[n].eRdy));
            chk($sformatf("v%0d_tag", n),
                32'(bus.alloc_tag), 32'(vecs[n].eTag));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", n), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_cnt", n),
                    32'(bus.count), 32'(e.eCnt));
                chk($sformatf("v%0d_rv", n),
                    32'(bus.recover_valid), 32'(e.eRv));
                chk($sformatf("v%0d_err", n),
                    32'(bus.error), 32'(e.eErr));
                if (e.eRv)
                    chk($sformatf("v%0d_rck", n),
                        32'(bus.recover_ckpt), 32'(e.eRck));
            end
        end

        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
